// File: rtl/operand_fetch_unit.sv
// Operand fetch unit: decode-side consumer of the 2R/1W register file.
// It drives the register file read addresses from the IF/ID fields and
// forwards EX/MEM/WB results into the operands. A load-use hazard inserts one
// bubble. The unit also owns the ID/EX pipeline register and its
// valid/ready handshake with execute.
//
// Ports:
//   CLK, RST                       clock, asynchronous active-high reset
//   id_valid / id_ready            IF/ID handshake
//   id_rs1, id_rs2, id_rd          source/destination register numbers
//   id_reg_write, id_is_load       decoded control bits
//   rf_a1, rf_a2 / rf_rd1, rf_rd2  register file read addresses / data
//   ex_result                      ALU result of the instruction in EX
//   mem_rd, mem_reg_write, mem_result
//                                  MEM-stage forwarding source
//   wb_rd, wb_reg_write, wb_data   WB-stage forwarding source
//   ex_ready, flush                execute back-pressure, pipeline flush
//   ex_valid, ex_rd, ex_reg_write, ex_is_load, ex_op1, ex_op2
//                                  ID/EX register outputs
//   stall_count                    saturating count of load-use bubbles
module operand_fetch_unit #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned AW   = 5
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            id_valid,
  output logic            id_ready,
  input  logic [AW-1:0]   id_rs1,
  input  logic [AW-1:0]   id_rs2,
  input  logic [AW-1:0]   id_rd,
  input  logic            id_reg_write,
  input  logic            id_is_load,
  output logic [AW-1:0]   rf_a1,
  output logic [AW-1:0]   rf_a2,
  input  logic [XLEN-1:0] rf_rd1,
  input  logic [XLEN-1:0] rf_rd2,
  input  logic [XLEN-1:0] ex_result,
  input  logic [AW-1:0]   mem_rd,
  input  logic            mem_reg_write,
  input  logic [XLEN-1:0] mem_result,
  input  logic [AW-1:0]   wb_rd,
  input  logic            wb_reg_write,
  input  logic [XLEN-1:0] wb_data,
  input  logic            ex_ready,
  input  logic            flush,
  output logic            ex_valid,
  output logic [AW-1:0]   ex_rd,
  output logic            ex_reg_write,
  output logic            ex_is_load,
  output logic [XLEN-1:0] ex_op1,
  output logic [XLEN-1:0] ex_op2,
  output logic [31:0]     stall_count
);

  typedef enum logic [0:0] {StRun, StHold} state_e;

  state_e          state_q, state_d;
  logic            ex_valid_q, ex_valid_d;
  logic [AW-1:0]   ex_rd_q, ex_rd_d;
  logic            ex_reg_write_q, ex_reg_write_d;
  logic            ex_is_load_q, ex_is_load_d;
  logic [XLEN-1:0] ex_op1_q, ex_op1_d;
  logic [XLEN-1:0] ex_op2_q, ex_op2_d;
  logic [31:0]     stall_count_q, stall_count_d;

  logic            freeze;
  logic            hazard;
  logic [XLEN-1:0] fwd1, fwd2;

  assign rf_a1 = id_rs1;
  assign rf_a2 = id_rs2;

  // A load in EX cannot forward its data yet, so a dependent instruction waits.
  assign hazard = ex_valid_q && ex_is_load_q && ex_reg_write_q && (ex_rd_q != '0) &&
                  ((ex_rd_q == id_rs1) || (ex_rd_q == id_rs2)) && id_valid;

  function automatic logic [XLEN-1:0] fwd_sel(input logic [AW-1:0]   rs,
                                              input logic [XLEN-1:0] rf_val);
    if (rs == '0) begin
      return '0;
    end else if (ex_valid_q && ex_reg_write_q && !ex_is_load_q && (ex_rd_q == rs)) begin
      return ex_result;
    end else if (mem_reg_write && (mem_rd == rs)) begin
      return mem_result;
    end else if (wb_reg_write && (wb_rd == rs)) begin
      return wb_data;
    end else begin
      return rf_val;
    end
  endfunction

  assign fwd1 = fwd_sel(id_rs1, rf_rd1);
  assign fwd2 = fwd_sel(id_rs2, rf_rd2);

  // HOLD tracks an occupied EX slot that execute has not taken yet.
  always_comb begin
    state_d = state_q;
    freeze  = 1'b0;
    unique case (state_q)
      StRun: begin
        freeze = ex_valid_q && !ex_ready;
        if (freeze) state_d = StHold;
      end
      StHold: begin
        freeze = !ex_ready;
        if (ex_ready) state_d = StRun;
      end
      default: state_d = StRun;
    endcase
    if (flush) state_d = StRun;
  end

  assign id_ready = !flush && !hazard && !freeze;

  always_comb begin
    ex_valid_d     = ex_valid_q;
    ex_rd_d        = ex_rd_q;
    ex_reg_write_d = ex_reg_write_q;
    ex_is_load_d   = ex_is_load_q;
    ex_op1_d       = ex_op1_q;
    ex_op2_d       = ex_op2_q;
    stall_count_d  = stall_count_q;
    if (flush) begin
      ex_valid_d = 1'b0;
    end else if (freeze) begin
      // Hold wins over a simultaneous hazard: nothing moves, nothing counted.
    end else if (hazard) begin
      ex_valid_d = 1'b0;
      if (stall_count_q != '1) stall_count_d = stall_count_q + 32'd1;
    end else if (id_valid) begin
      ex_valid_d     = 1'b1;
      ex_rd_d        = id_rd;
      ex_reg_write_d = id_reg_write;
      ex_is_load_d   = id_is_load;
      ex_op1_d       = fwd1;
      ex_op2_d       = fwd2;
    end else begin
      ex_valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q        <= StRun;
      ex_valid_q     <= 1'b0;
      ex_rd_q        <= '0;
      ex_reg_write_q <= 1'b0;
      ex_is_load_q   <= 1'b0;
      ex_op1_q       <= '0;
      ex_op2_q       <= '0;
      stall_count_q  <= '0;
    end else begin
      state_q        <= state_d;
      ex_valid_q     <= ex_valid_d;
      ex_rd_q        <= ex_rd_d;
      ex_reg_write_q <= ex_reg_write_d;
      ex_is_load_q   <= ex_is_load_d;
      ex_op1_q       <= ex_op1_d;
      ex_op2_q       <= ex_op2_d;
      stall_count_q  <= stall_count_d;
    end
  end

  assign ex_valid     = ex_valid_q;
  assign ex_rd        = ex_rd_q;
  assign ex_reg_write = ex_reg_write_q;
  assign ex_is_load   = ex_is_load_q;
  assign ex_op1       = ex_op1_q;
  assign ex_op2       = ex_op2_q;
  assign stall_count  = stall_count_q;

endmodule

// File: tb/tb_operand_fetch_unit.sv
// Testbench for operand_fetch_unit: directed scenarios followed by random
// traffic, all checked against a transaction-level model of the ID/EX slot.
module tb_operand_fetch_unit;

  localparam int XLEN = 32;
  localparam int AW   = 5;

  logic            CLK = 1'b0;
  logic            RST;
  logic            id_valid, id_ready;
  logic [AW-1:0]   id_rs1, id_rs2, id_rd;
  logic            id_reg_write, id_is_load;
  logic [AW-1:0]   rf_a1, rf_a2;
  logic [XLEN-1:0] rf_rd1, rf_rd2;
  logic [XLEN-1:0] ex_result;
  logic [AW-1:0]   mem_rd;
  logic            mem_reg_write;
  logic [XLEN-1:0] mem_result;
  logic [AW-1:0]   wb_rd;
  logic            wb_reg_write;
  logic [XLEN-1:0] wb_data;
  logic            ex_ready, flush;
  logic            ex_valid;
  logic [AW-1:0]   ex_rd;
  logic            ex_reg_write, ex_is_load;
  logic [XLEN-1:0] ex_op1, ex_op2;
  logic [31:0]     stall_count;

  logic [XLEN-1:0] regs [32];

  int checks   = 0;
  int failures = 0;

  // Model of the ID/EX slot as one instruction record plus a bubble counter.
  typedef struct {
    bit          valid;
    bit [4:0]    rd;
    bit          rw;
    bit          load;
    bit [31:0]   op1;
    bit [31:0]   op2;
    longint      stalls;
  } slot_t;
  slot_t m;

  always #5 CLK = ~CLK;

  assign rf_rd1 = regs[id_rs1];
  assign rf_rd2 = regs[id_rs2];

  operand_fetch_unit #(.XLEN(XLEN), .AW(AW)) u_dut (
    .CLK(CLK), .RST(RST),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_is_load(id_is_load),
    .rf_a1(rf_a1), .rf_a2(rf_a2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
    .ex_result(ex_result),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_result(mem_result),
    .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_data(wb_data),
    .ex_ready(ex_ready), .flush(flush),
    .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .ex_is_load(ex_is_load), .ex_op1(ex_op1), .ex_op2(ex_op2),
    .stall_count(stall_count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Value the instruction should see for register rs after bypassing.
  function automatic bit [31:0] operand(input bit [4:0] rs, input bit [31:0] rf_val);
    if (rs == 0) return 0;
    if (m.valid && m.rw && !m.load && m.rd == rs) return ex_result;
    if (mem_reg_write && mem_rd == rs) return mem_result;
    if (wb_reg_write && wb_rd == rs) return wb_data;
    return rf_val;
  endfunction

  task automatic check_slot(input string tag);
    chk({tag, ".ex_valid"}, 64'(ex_valid), 64'(m.valid));
    chk({tag, ".stall_count"}, 64'(stall_count), 64'(m.stalls));
    if (m.valid) begin
      chk({tag, ".ex_rd"}, 64'(ex_rd), 64'(m.rd));
      chk({tag, ".ex_reg_write"}, 64'(ex_reg_write), 64'(m.rw));
      chk({tag, ".ex_is_load"}, 64'(ex_is_load), 64'(m.load));
      chk({tag, ".ex_op1"}, 64'(ex_op1), 64'(m.op1));
      chk({tag, ".ex_op2"}, 64'(ex_op2), 64'(m.op2));
    end
  endtask

  // One clock: check the combinational outputs, predict the slot, then advance.
  task automatic step(input string tag);
    bit    slot_free, waits_on_load, accept;
    slot_t nxt;
    #1;
    slot_free     = !m.valid || ex_ready;
    waits_on_load = id_valid && m.valid && m.load && m.rw && m.rd != 0 &&
                    (m.rd == id_rs1 || m.rd == id_rs2);
    accept        = !flush && slot_free && !waits_on_load && id_valid;
    chk({tag, ".id_ready"}, 64'(id_ready), 64'(!flush && slot_free && !waits_on_load));
    chk({tag, ".rf_a1"}, 64'(rf_a1), 64'(id_rs1));
    chk({tag, ".rf_a2"}, 64'(rf_a2), 64'(id_rs2));
    nxt = m;
    if (accept) begin
      nxt.valid = 1;
      nxt.rd    = id_rd;
      nxt.rw    = id_reg_write;
      nxt.load  = id_is_load;
      nxt.op1   = operand(id_rs1, rf_rd1);
      nxt.op2   = operand(id_rs2, rf_rd2);
    end else if (flush || slot_free) begin
      nxt.valid = 0;
    end
    if (!flush && slot_free && waits_on_load && nxt.stalls < 64'hFFFF_FFFF) nxt.stalls++;
    @(posedge CLK);
    #1;
    m = nxt;
    check_slot(tag);
  endtask

  task automatic set_id(input bit v, input bit [4:0] rs1, input bit [4:0] rs2,
                        input bit [4:0] rd, input bit rw, input bit ld);
    id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    id_reg_write = rw; id_is_load = ld;
  endtask

  task automatic model_reset();
    m = '{valid: 0, rd: 0, rw: 0, load: 0, op1: 0, op2: 0, stalls: 0};
  endtask

  initial begin
    logic [31:0] saved_op1;
    logic [31:0] saved_stalls;
    for (int i = 0; i < 32; i++) regs[i] = 32'h1000 + i;
    set_id(0, 0, 0, 0, 0, 0);
    ex_result = 0; mem_rd = 0; mem_reg_write = 0; mem_result = 0;
    wb_rd = 0; wb_reg_write = 0; wb_data = 0; ex_ready = 1; flush = 0;
    model_reset();

    // Reset
    RST = 1;
    #12;
    chk("reset.ex_valid", 64'(ex_valid), 0);
    chk("reset.ex_rd", 64'(ex_rd), 0);
    chk("reset.ex_reg_write", 64'(ex_reg_write), 0);
    chk("reset.ex_is_load", 64'(ex_is_load), 0);
    chk("reset.ex_op1", 64'(ex_op1), 0);
    chk("reset.ex_op2", 64'(ex_op2), 0);
    chk("reset.stall_count", 64'(stall_count), 0);
    @(negedge CLK);
    RST = 0;

    // Basic accept from the register file
    regs[3] = 32'h11; regs[4] = 32'h22;
    set_id(1, 3, 4, 5, 1, 0);
    step("basic");
    chk("basic.op1_const", 64'(ex_op1), 64'h11);
    chk("basic.op2_const", 64'(ex_op2), 64'h22);

    // EX beats MEM
    ex_result = 32'hAAAA; mem_rd = 5; mem_reg_write = 1; mem_result = 32'hBBBB;
    set_id(1, 5, 0, 6, 1, 0);
    step("fwd_ex");
    chk("fwd_ex.op1_const", 64'(ex_op1), 64'hAAAA);
    // EX now targets rd=6, so MEM supplies rs1=5
    step("fwd_mem");
    chk("fwd_mem.op1_const", 64'(ex_op1), 64'hBBBB);
    // Only WB targets rd=5
    mem_reg_write = 0; wb_rd = 5; wb_reg_write = 1; wb_data = 32'hCCCC;
    step("fwd_wb");
    chk("fwd_wb.op1_const", 64'(ex_op1), 64'hCCCC);
    wb_reg_write = 0;

    // Load-use: one bubble then MEM forwarding of the load data
    set_id(1, 1, 2, 7, 1, 1);
    step("ld_issue");
    set_id(1, 2, 7, 8, 1, 0);
    step("ld_bubble");
    chk("ld_bubble.valid_const", 64'(ex_valid), 0);
    chk("ld_bubble.stall_const", 64'(stall_count), 1);
    mem_rd = 7; mem_reg_write = 1; mem_result = 32'hDDDD;
    step("ld_resume");
    chk("ld_resume.op2_const", 64'(ex_op2), 64'hDDDD);
    mem_reg_write = 0;

    // x0 always reads zero
    set_id(1, 1, 1, 0, 1, 0);
    step("x0_setup");
    regs[0] = 32'h5555; ex_result = 32'h1234; mem_rd = 0; mem_reg_write = 1;
    mem_result = 32'h4321; wb_rd = 0; wb_reg_write = 1; wb_data = 32'h9999;
    set_id(1, 0, 0, 9, 1, 0);
    step("x0");
    chk("x0.op1_const", 64'(ex_op1), 0);
    mem_reg_write = 0; wb_reg_write = 0;

    // Back-pressure with a pending load-use hazard
    set_id(1, 3, 3, 7, 1, 1);
    step("bp_load");
    saved_op1 = ex_op1; saved_stalls = stall_count;
    ex_ready = 0;
    set_id(1, 7, 2, 10, 1, 0);
    for (int i = 0; i < 3; i++) begin
      step("bp_hold");
      chk("bp_hold.op1_frozen", 64'(ex_op1), 64'(saved_op1));
      chk("bp_hold.stall_frozen", 64'(stall_count), 64'(saved_stalls));
    end

    // Flush during hold
    flush = 1;
    step("flush");
    chk("flush.valid_const", 64'(ex_valid), 0);
    flush = 0;
    set_id(1, 2, 3, 11, 1, 0);
    step("after_flush");
    chk("after_flush.valid_const", 64'(ex_valid), 1);
    ex_ready = 1;

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      set_id($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
             5'($urandom_range(0, 7)), $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0);
      ex_ready      = $urandom_range(0, 3) != 0;
      flush         = $urandom_range(0, 15) == 0;
      ex_result     = $urandom;
      mem_rd        = 5'($urandom_range(0, 7));
      mem_reg_write = $urandom_range(0, 1) == 1;
      mem_result    = $urandom;
      wb_rd         = 5'($urandom_range(0, 7));
      wb_reg_write  = $urandom_range(0, 1) == 1;
      wb_data       = $urandom;
      regs[$urandom_range(0, 7)] = $urandom;
      step("rand");
    end

    // Asynchronous reset mid-operation
    flush = 0; ex_ready = 1;
    set_id(1, 1, 2, 3, 1, 0);
    step("pre_rst");
    @(negedge CLK);
    RST = 1;
    #1;
    model_reset();
    chk("async_rst.ex_valid", 64'(ex_valid), 0);
    chk("async_rst.ex_op1", 64'(ex_op1), 0);
    chk("async_rst.stall_count", 64'(stall_count), 0);
    #2;
    RST = 0;
    step("post_rst");
    chk("post_rst.valid_const", 64'(ex_valid), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
